instr_encoder_loader: RTL

//  Inverse of the opcode decoder: accepts symbolic instruction records over a valid/ready stream, encodes each into
//  a 32-bit MIPS word and writes it sequentially into instruction memory. Holds the CPU in reset while loading.

---
 rtl/mips_isa_pkg.sv | 48 ++++
 rtl/instr_encode.sv | 56 +++++
 rtl/instr_encoder_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS subset opcode/funct constants, instruction kinds and loader states shared by
// the instruction encoder/loader and the opcode decoder.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    K_ADD  = 5'd0,  K_SUB  = 5'd1,  K_AND  = 5'd2,  K_OR   = 5'd3,
    K_SLT  = 5'd4,  K_SLL  = 5'd5,  K_SRL  = 5'd6,  K_JR   = 5'd7,
    K_ADDI = 5'd8,  K_SLTI = 5'd9,  K_ANDI = 5'd10, K_ORI  = 5'd11,
    K_LW   = 5'd12, K_SW   = 5'd13, K_LI   = 5'd14, K_BEQ  = 5'd15,
    K_BNE  = 5'd16, K_J    = 5'd17, K_JAL  = 5'd18
  } kind_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} ld_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LI    = 6'b010000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: instruction kind + fields + word address -> 32-bit MIPS word,
// flagging kinds outside the supported set.
module instr_encode
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [4:0]        i_kind,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_shamt,
  input  logic [15:0]       i_imm,
  input  logic [ADDR_W-1:0] i_target,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [31:0]       o_word,
  output logic              o_illegal
);

  logic [ADDR_W-1:0] w_rel;
  logic [15:0]       w_br_imm;
  logic [25:0]       w_jtarget;

  // Branch offset is relative to the following word, computed modulo the address space.
  assign w_rel     = i_target - i_pc - ADDR_W'(1);
  assign w_br_imm  = 16'($signed(w_rel));
  assign w_jtarget = 26'(i_target);

  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (i_kind)
      K_ADD:  o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FUNCT_ADD);
      K_SUB:  o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FUNCT_SUB);
      K_AND:  o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FUNCT_AND);
      K_OR:   o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FUNCT_OR);
      K_SLT:  o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FUNCT_SLT);
      K_SLL:  o_word = enc_r(5'd0, i_rt, i_rd, i_shamt, FUNCT_SLL);
      K_SRL:  o_word = enc_r(5'd0, i_rt, i_rd, i_shamt, FUNCT_SRL);
      K_JR:   o_word = enc_r(i_rs, 5'd0, 5'd0, 5'd0, FUNCT_JR);
      K_ADDI: o_word = enc_i(OP_ADDI, i_rs, i_rt, i_imm);
      K_SLTI: o_word = enc_i(OP_SLTI, i_rs, i_rt, i_imm);
      K_ANDI: o_word = enc_i(OP_ANDI, i_rs, i_rt, i_imm);
      K_ORI:  o_word = enc_i(OP_ORI, i_rs, i_rt, i_imm);
      K_LW:   o_word = enc_i(OP_LW, i_rs, i_rt, i_imm);
      K_SW:   o_word = enc_i(OP_SW, i_rs, i_rt, i_imm);
      K_LI:   o_word = enc_i(OP_LI, 5'd0, i_rt, i_imm);
      K_BEQ:  o_word = enc_i(OP_BEQ, i_rs, i_rt, w_br_imm);
      K_BNE:  o_word = enc_i(OP_BNE, i_rs, i_rt, w_br_imm);
      K_J:    o_word = {OP_J, w_jtarget};
      K_JAL:  o_word = {OP_JAL, w_jtarget};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams symbolic instruction records into instruction memory as encoded MIPS words,
// holding the CPU in reset until a session completes. LOADER_CHECKSUM_EN adds an XOR checksum.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [ADDR_W-1:0] in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic              cpu_hold
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  ld_state_e         r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_index;
  logic              r_last_taken;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [CNT_W-1:0]  r_count;
  logic              r_hold;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       r_csum;
`endif

  logic [31:0]       w_word;
  logic              w_illegal;
  logic [ADDR_W-1:0] w_pc;
  logic [CNT_W-1:0]  w_span;
  logic              w_overflow;
  logic              w_ready;
  logic              w_accept;
  logic              w_wr_hs;

  // r_index counts accepted records; each accepted record is written exactly once.
  assign w_pc       = r_base + r_index[ADDR_W-1:0];
  assign w_span     = CNT_W'(r_base) + r_index;
  assign w_overflow = (w_span >= CNT_W'(DEPTH));
  assign w_ready    = (r_state == ST_LOAD) & ~r_last_taken & (~r_we | imem_ready);
  assign w_accept   = in_valid & w_ready;
  assign w_wr_hs    = r_we & imem_ready;

  instr_encode #(.ADDR_W(ADDR_W)) u_encode (
    .i_kind    (in_kind),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_shamt   (in_shamt),
    .i_imm     (in_imm),
    .i_target  (in_target),
    .i_pc      (w_pc),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_index      <= '0;
      r_last_taken <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_count      <= '0;
      r_hold       <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_state      <= ST_LOAD;
            r_base       <= base_addr;
            r_index      <= '0;
            r_last_taken <= 1'b0;
            r_count      <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_hold       <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (w_wr_hs) begin
            r_we    <= 1'b0;
            r_count <= r_count + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ r_wdata;
`endif
            if (r_last_taken) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end
          end
          // A new record may be accepted in the same cycle the previous write completes.
          if (w_accept) begin
            if (w_illegal || w_overflow) begin
              r_state <= ST_ERR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_we         <= 1'b1;
              r_addr       <= w_pc;
              r_wdata      <= w_word;
              r_index      <= r_index + CNT_W'(1);
              r_last_taken <= in_last;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = w_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign count      = r_count;
  assign cpu_hold   = r_hold;
`ifdef LOADER_CHECKSUM_EN
  assign checksum   = r_csum;
`endif

endmodule
